// File: rtl/product_acc_pkg.sv
// Shared types and default widths for the product accumulator slice.
package product_acc_pkg;

    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_CNT_W  = 8;
    localparam int NBYTES     = DEF_ACC_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_e;

endpackage

// File: rtl/acc_add_sat.sv
// Combinational accumulator adder. PRODUCT_ACC_SATURATE_EN selects clamping
// at 2^ACC_W-1 (flagged on ovf_o); otherwise the sum wraps and ovf_o stays 0.
module acc_add_sat
    import product_acc_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int PROD_W = DEF_PROD_W
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] add_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

`ifdef PRODUCT_ACC_SATURATE_EN
    logic [ACC_W:0] full_sum;

    assign full_sum = {1'b0, acc_i} + (ACC_W+1)'(add_i);
    assign sum_o    = full_sum[ACC_W] ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
    assign ovf_o    = full_sum[ACC_W];
`else
    assign sum_o = acc_i + ACC_W'(add_i);
    assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmed run of products, then streams the sum out LSB byte first.
// Optional saturation on overflow: define PRODUCT_ACC_SATURATE_EN.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clear,
    input  logic [CNT_W-1:0]  len,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              sat
);

    localparam int NB     = ACC_W / 8;
    localparam int BIDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(NB - 1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [BIDX_W-1:0]  bidx_q, bidx_d;
    logic               sat_q, sat_d;

    logic [ACC_W-1:0]   sum;
    logic               ovf;
    logic               accept;
    logic               out_fire;
    logic [CNT_W:0]     eff_len;
    logic [CNT_W:0]     cnt_inc;

    acc_add_sat #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_add (
        .acc_i (acc_q),
        .add_i (prod_in),
        .sum_o (sum),
        .ovf_o (ovf)
    );

    assign prod_ready = ena && !clear && (state_q != ST_EMIT);
    assign accept     = prod_ready && prod_valid;
    assign out_valid  = ena && (state_q == ST_EMIT);
    assign out_fire   = out_valid && out_ready && !clear;
    assign out_byte   = acc_q[{bidx_q, 3'b000} +: 8];
    assign busy       = (state_q != ST_IDLE);
    assign sat        = sat_q;

    // A stored length of zero stands for a full 2^CNT_W-product run.
    assign eff_len = (len_q == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len_q};
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        bidx_d  = bidx_q;
        sat_d   = sat_q;
        if (ena) begin
            if (clear) begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                bidx_d  = '0;
                sat_d   = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            acc_d   = ACC_W'(prod_in);
                            cnt_d   = CNT_W'(1);
                            len_d   = len;
                            sat_d   = 1'b0;
                            state_d = (len == CNT_W'(1)) ? ST_EMIT : ST_ACCUM;
                        end
                    end
                    ST_ACCUM: begin
                        if (accept) begin
                            acc_d = sum;
                            cnt_d = cnt_inc[CNT_W-1:0];
                            sat_d = sat_q | ovf;
                            if (cnt_inc == eff_len) begin
                                state_d = ST_EMIT;
                            end
                        end
                    end
                    ST_EMIT: begin
                        if (out_fire) begin
                            if (bidx_q == LAST_BIDX) begin
                                bidx_d  = '0;
                                state_d = ST_IDLE;
                            end else begin
                                bidx_d = bidx_q + BIDX_W'(1);
                            end
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            bidx_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            bidx_q  <= bidx_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomised and directed checks of product_accumulator (16-bit acc, 8-bit count).
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        clear;
    logic [7:0]  len;
    logic [15:0] prod_in;
    logic        prod_valid;
    logic        prod_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        sat;

    int n_tests = 0;
    int n_fail  = 0;

    product_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .clear      (clear),
        .len        (len),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    // Reference: running unsigned sum, clamped or wrapped after every add.
    function automatic logic [16:0] model_run(input logic [15:0] ps[$]);
        longint s  = 0;
        bit     st = 1'b0;
        foreach (ps[i]) begin
            s += longint'(ps[i]);
            if (s > 65535) begin
`ifdef PRODUCT_ACC_SATURATE_EN
                s  = 65535;
                st = 1'b1;
`else
                s -= 65536;
`endif
            end
        end
        return {st, s[15:0]};
    endfunction

    // Present one product and return once it has been accepted (bounded wait).
    task automatic send(input logic [15:0] p, output bit ok);
        ok         = 1'b0;
        prod_in    = p;
        prod_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (prod_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        prod_valid = 1'b0;
    endtask

    task automatic get_byte(output logic [7:0] b, output bit ok);
        ok        = 1'b0;
        b         = 8'h00;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (out_valid) begin
                b  = out_byte;
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; clear = 1'b0; len = 8'd0;
        prod_in = 16'h0; prod_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({prod_ready, out_valid, busy, sat} !== 4'b0000 || out_byte !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b busy=%b sat=%b byte=%h, want 0 0 0 0 00",
                     prod_ready, out_valid, busy, sat, out_byte);
        end
        rst_n = 1'b1;
        ena   = 1'b1;
        #1;
        n_tests++;
        if (prod_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after_ena: got %b want 1", prod_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        len = 8'd3;
        send(16'h0102, ok);
        send(16'h0010, ok);
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_valid: got out_valid=%b want 0", out_valid);
        end
        send(16'h0001, ok);
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_byte !== 8'h13) begin
            n_fail++;
            $display("FAIL basic_byte0: got valid=%b byte=%h want 1 13", out_valid, out_byte);
        end
        @(negedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_byte !== 8'h01) begin
            n_fail++;
            $display("FAIL basic_byte1: got valid=%b byte=%h want 1 01", out_valid, out_byte);
        end
        @(negedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got valid=%b busy=%b want 0 0", out_valid, busy);
        end
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        bit          ok, ok2;
        logic [7:0]  b0, b1;
        logic [15:0] ps[$];
        logic [16:0] exp;
        ps  = '{16'hFFFF, 16'h0002};
        exp = model_run(ps);
        len = 8'd2;
        foreach (ps[i]) send(ps[i], ok);
        #1;
        n_tests++;
        if (sat !== exp[16]) begin
            n_fail++;
            $display("FAIL overflow_sat_emit: got %b want %b", sat, exp[16]);
        end
        get_byte(b0, ok);
        get_byte(b1, ok2);
        n_tests++;
        if (!ok || !ok2 || {b1, b0} !== exp[15:0] || sat !== exp[16]) begin
            n_fail++;
            $display("FAIL overflow_result: got %h%h sat=%b ok=%b%b want %h sat=%b",
                     b1, b0, sat, ok, ok2, exp[15:0], exp[16]);
        end
    endtask

    task automatic test_backpressure();
        bit         ok, ok2;
        logic [7:0] b0, b1;
        len = 8'd1;
        send(16'hABCD, ok);
        prod_in    = 16'h1111;
        prod_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (out_valid !== 1'b1 || out_byte !== 8'hCD || prod_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: got valid=%b byte=%h rdy=%b want 1 cd 0",
                         i, out_valid, out_byte, prod_ready);
            end
            @(negedge clk);
        end
        prod_valid = 1'b0;
        get_byte(b0, ok);
        get_byte(b1, ok2);
        n_tests++;
        if (!ok || !ok2 || b0 !== 8'hCD || b1 !== 8'hAB) begin
            n_fail++;
            $display("FAIL stall_release: got %h %h want cd ab", b0, b1);
        end
    endtask

    task automatic test_len_zero();
        bit         ok, ok2;
        logic [7:0] b0, b1;
        len = 8'd0;
        for (int i = 0; i < 255; i++) send(16'h0001, ok);
        #1;
        n_tests++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_after255: got busy=%b valid=%b want 1 0", busy, out_valid);
        end
        send(16'h0001, ok);
        get_byte(b0, ok);
        get_byte(b1, ok2);
        n_tests++;
        if (!ok || !ok2 || b0 !== 8'h00 || b1 !== 8'h01) begin
            n_fail++;
            $display("FAIL len0_result: got %h %h want 00 01", b0, b1);
        end
    endtask

    task automatic test_clear();
        bit         ok, ok2;
        logic [7:0] b0, b1;
        len = 8'd4;
        send(16'h0100, ok);
        send(16'h0200, ok);
        clear      = 1'b1;
        prod_in    = 16'h7777;
        prod_valid = 1'b1;
        #1;
        n_tests++;
        if (prod_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_ready: got %b want 0", prod_ready);
        end
        @(negedge clk);
        clear      = 1'b0;
        prod_valid = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_state: got busy=%b valid=%b sat=%b want 0 0 0", busy, out_valid, sat);
        end
        len = 8'd1;
        send(16'h0005, ok);
        get_byte(b0, ok);
        get_byte(b1, ok2);
        n_tests++;
        if (!ok || !ok2 || b0 !== 8'h05 || b1 !== 8'h00) begin
            n_fail++;
            $display("FAIL clear_fresh_run: got %h %h want 05 00", b0, b1);
        end
    endtask

    task automatic test_ena();
        bit          ok, ok2;
        logic [7:0]  b0, b1;
        logic [15:0] ps[$];
        logic [16:0] exp;
        for (int i = 0; i < 4; i++) ps.push_back(16'($urandom_range(0, 16'hFFFF)));
        exp = model_run(ps);
        len = 8'd4;
        send(ps[0], ok);
        send(ps[1], ok);
        ena        = 1'b0;
        prod_in    = 16'hFFFF;
        prod_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (prod_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL ena_accum_cycle%0d: got rdy=%b busy=%b want 0 1", i, prod_ready, busy);
            end
            @(negedge clk);
        end
        prod_valid = 1'b0;
        ena        = 1'b1;
        send(ps[2], ok);
        send(ps[3], ok);
        get_byte(b0, ok);
        ena       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ena_emit_cycle%0d: got out_valid=%b want 0", i, out_valid);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        ena       = 1'b1;
        get_byte(b1, ok2);
        n_tests++;
        if (!ok || !ok2 || {b1, b0} !== exp[15:0] || sat !== exp[16]) begin
            n_fail++;
            $display("FAIL ena_result: got %h%h sat=%b want %h sat=%b", b1, b0, sat, exp[15:0], exp[16]);
        end
    endtask

    task automatic test_random();
        bit          ok, ok2, sent_ok;
        logic [7:0]  b0, b1;
        logic [15:0] ps[$];
        logic [16:0] exp;
        int          n;
        for (int r = 0; r < 20; r++) begin
            ps.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) ps.push_back(16'($urandom_range(0, 16'hFFFF)));
            exp     = model_run(ps);
            len     = 8'(n);
            sent_ok = 1'b1;
            foreach (ps[i]) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                send(ps[i], ok);
                sent_ok &= ok;
                len = 8'($urandom_range(0, 255));
            end
            #1;
            n_tests++;
            if (!sent_ok || out_valid !== 1'b1 || sat !== exp[16]) begin
                n_fail++;
                $display("FAIL rand%0d_emit: got sent=%b valid=%b sat=%b want 1 1 %b",
                         r, sent_ok, out_valid, sat, exp[16]);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            get_byte(b0, ok);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            get_byte(b1, ok2);
            n_tests++;
            if (!ok || !ok2 || {b1, b0} !== exp[15:0]) begin
                n_fail++;
                $display("FAIL rand%0d_result: got %h%h want %h (len %0d)", r, b1, b0, exp[15:0], n);
            end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        len = 8'd3;
        send(16'h1234, ok);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || out_byte !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b byte=%h want 0 00", busy, out_byte);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_len_zero();
        test_clear();
        test_ena();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
